// File: rtl/dac_pkg.sv
// Shared definitions for the DAC playback engine.
//   - one-hot state encodings of the playback FSM
//   - power-up settle length in clock cycles
//   - sample order within a memory word (matches the ADC capture packing)
package dac_pkg;

    localparam int STATE_WIDTH = 5;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE    = 5'b00001,
        S_POWERUP = 5'b00010,
        S_PLAY1   = 5'b00100,
        S_PLAY2   = 5'b01000,
        S_END     = 5'b10000
    } state_t;

    localparam int PWRUP_CYCLES = 32;

    // The first sample played from a word is its high byte.
    localparam bit HIGH_BYTE_FIRST = 1'b1;

endpackage

// File: rtl/dac_fifo.sv
// Two-entry prefetch buffer between the memory read port and the sample
// player.
//   clock, reset_n : clock, asynchronous active-low reset
//   clear          : synchronous flush to empty
//   push, din      : write one word (ignored when full unless popping)
//   pop            : drop the head word (ignored when empty)
//   head           : oldest word, valid when count != 0
//   count          : number of words held, 0..2
module dac_fifo #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = entry0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else if (clear) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= din;
                    else               entry1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps the occupancy; the new word
                    // lands behind whatever survives the pop.
                    if (count == 2'd1) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dac.sv
// Playback engine for the 8-bit DAC. On enable it powers the DAC up, reads
// the whole sample memory from word 0 to the last word over Avalon-MM and
// plays two samples per word, one per clock.
//   clock, reset_n     : system clock, asynchronous active-low reset
//   enable             : start request, honoured only while finished
//   done, underrun     : finished flag, sticky empty-buffer stall flag
//   mem_*              : Avalon-MM read master (byteenable fixed all-ones)
//   dac_pwrdwn         : DAC power-down, high while finished
//   dac_clock(_en)     : forwarded clock and its enable
//   dac_d              : registered sample
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | one cycle: clear address, buffer, flags, load settle timer
// S_POWERUP | DAC settling, prefetch running
// S_PLAY1   | drive first sample of head word, or stall if buffer empty
// S_PLAY2   | drive second sample of head word and pop it
// S_END     | finished, DAC powered down, waiting for enable
module dac
    import dac_pkg::*;
#(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int DAC_WIDTH   = 8,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  done,
    output logic                  underrun,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_waitrequest,
    output logic                  dac_pwrdwn,
    output logic                  dac_clock,
    output logic                  dac_clock_en,
    output logic [DAC_WIDTH-1:0]  dac_d
);

    state_t                 state;
    state_t                 state_nxt;
    logic [COUNT_WIDTH-1:0] pwrup_counter;
    logic                   fetch_done;
    logic                   accept;
    logic                   last_word;
    logic                   fifo_clear;
    logic                   fifo_pop;
    logic [DATA_WIDTH-1:0]  head;
    logic [1:0]             count;
    logic [DAC_WIDTH-1:0]   first_sample;
    logic [DAC_WIDTH-1:0]   second_sample;

    assign mem_byteenable = '1;
    assign dac_clock      = clock;

    assign accept    = mem_read && !mem_waitrequest;
    assign last_word = fetch_done && (count == 2'd1);

    assign first_sample  = HIGH_BYTE_FIRST ? head[DATA_WIDTH-1 -: DAC_WIDTH] : head[DAC_WIDTH-1:0];
    assign second_sample = HIGH_BYTE_FIRST ? head[DAC_WIDTH-1:0] : head[DATA_WIDTH-1 -: DAC_WIDTH];

    dac_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (fifo_clear),
        .push    (accept),
        .pop     (fifo_pop),
        .din     (mem_readdata),
        .head    (head),
        .count   (count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_END;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    state_nxt = S_POWERUP;
            S_POWERUP: if (pwrup_counter == '0) state_nxt = S_PLAY1;
            S_PLAY1:   if (count != 2'd0) state_nxt = S_PLAY2;
            S_PLAY2:   state_nxt = last_word ? S_END : S_PLAY1;
            S_END:     if (enable) state_nxt = S_IDLE;
            default:   state_nxt = S_END;
        endcase
    end

    // The request can only drop through fetch_done or a full buffer; during
    // a stall nothing is pushed, so once raised it holds until accepted.
    always_comb begin
        done         = (state == S_END);
        dac_pwrdwn   = (state == S_END);
        dac_clock_en = (state != S_END);
        fifo_clear   = (state == S_IDLE);
        fifo_pop     = (state == S_PLAY2);
        mem_read     = ((state == S_POWERUP) || (state == S_PLAY1) || (state == S_PLAY2))
                       && !fetch_done && (count < 2'd2);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_address   <= '0;
            fetch_done    <= 1'b0;
            underrun      <= 1'b0;
            dac_d         <= '0;
            pwrup_counter <= '0;
        end else begin
            // The last address stops the fetch rather than wrapping to 0.
            if (accept) begin
                if (&mem_address) fetch_done  <= 1'b1;
                else              mem_address <= mem_address + ADDR_WIDTH'(1);
            end
            case (state)
                S_IDLE: begin
                    mem_address   <= '0;
                    fetch_done    <= 1'b0;
                    underrun      <= 1'b0;
                    dac_d         <= '0;
                    pwrup_counter <= COUNT_WIDTH'(PWRUP_CYCLES - 1);
                end
                S_POWERUP: begin
                    if (pwrup_counter != '0) pwrup_counter <= pwrup_counter - COUNT_WIDTH'(1);
                end
                S_PLAY1: begin
                    if (count != 2'd0) dac_d    <= first_sample;
                    else               underrun <= 1'b1;
                end
                S_PLAY2: begin
                    dac_d <= second_sample;
                end
                default: ;
            endcase
        end
    end

endmodule
